// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 active-low keypad, debounces one key per full scan,
// and assembles a 0..9999 decimal value; '*' clears it and '#' commits it to entry.
`ifndef CLK_FREQ
`define CLK_FREQ 50_000_000
`endif

module keypad_entry #(
  parameter int unsigned CLK_FREQ       = `CLK_FREQ,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [15:0] value,
  output logic [2:0]  digit_cnt,
  output logic [15:0] entry,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        entry_done
);

  localparam int unsigned SCAN_MAX = CLK_FREQ / SCAN_HZ;
  localparam int unsigned DW_W     = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;
  localparam int unsigned SC_W     = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_HELD   = 2'd2
  } state_e;

  logic [3:0]      col_meta_q, col_meta_d;
  logic [3:0]      col_sync_q, col_sync_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      row_n_q, row_n_d;
  logic [11:0]     snap_q, snap_d;
  state_e          state_q, state_d;
  logic [SC_W-1:0] stable_q, stable_d;
  logic [3:0]      key_idx_q, key_idx_d;
  logic [15:0]     value_q, value_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [15:0]     entry_q, entry_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            entry_done_q, entry_done_d;

  logic            last_dwell_c;
  logic            scan_done_c;
  logic [15:0]     down_c;
  logic [4:0]      n_down_c;
  logic [3:0]      down_idx_c;
  logic            one_down_c;
  logic            none_down_c;
  logic            accept_c;
  logic [3:0]      acc_code_c;

  // Physical key position (4*row+col) to key code.
  function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd10;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'd11;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'd12;
      4'd12:   code = 4'd14;
      4'd13:   code = 4'd0;
      4'd14:   code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  assign last_dwell_c = (dwell_q == DW_W'(SCAN_MAX - 1));
  assign scan_done_c  = last_dwell_c && (row_q == 2'd3);

  // Row3 is taken live from the synchronizer so the scan is judged on its final sample.
  always_comb begin
    down_c     = ~{col_sync_q, snap_q};
    n_down_c   = '0;
    down_idx_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (down_c[i]) begin
        n_down_c   = n_down_c + 5'd1;
        down_idx_c = 4'(i);
      end
    end
    one_down_c  = (n_down_c == 5'd1);
    none_down_c = (n_down_c == 5'd0);
    acc_code_c  = idx_to_code(down_idx_c);
  end

  always_comb begin
    col_meta_d   = col_n;
    col_sync_d   = col_meta_q;
    dwell_d      = dwell_q + DW_W'(1);
    row_d        = row_q;
    row_n_d      = row_n_q;
    snap_d       = snap_q;
    state_d      = state_q;
    stable_d     = stable_q;
    key_idx_d    = key_idx_q;
    value_d      = value_q;
    cnt_d        = cnt_q;
    entry_d      = entry_q;
    key_code_d   = key_code_q;
    key_valid_d  = 1'b0;
    entry_done_d = 1'b0;
    accept_c     = 1'b0;

    if (last_dwell_c) begin
      dwell_d = '0;
      row_d   = row_q + 2'd1;
      row_n_d = {row_n_q[2:0], row_n_q[3]};
      case (row_q)
        2'd0:    snap_d[3:0]  = col_sync_q;
        2'd1:    snap_d[7:4]  = col_sync_q;
        2'd2:    snap_d[11:8] = col_sync_q;
        default: snap_d       = snap_q;
      endcase
    end

    // Debounce decisions happen once per completed scan.
    if (scan_done_c) begin
      case (state_q)
        ST_IDLE: begin
          if (one_down_c) begin
            key_idx_d = down_idx_c;
            if (DEBOUNCE_SCANS <= 1) begin
              accept_c = 1'b1;
              stable_d = '0;
              state_d  = ST_HELD;
            end else begin
              stable_d = SC_W'(1);
              state_d  = ST_ARMING;
            end
          end
        end
        ST_ARMING: begin
          if (one_down_c && (down_idx_c == key_idx_q)) begin
            if (32'(stable_q) + 32'd1 >= DEBOUNCE_SCANS) begin
              accept_c = 1'b1;
              stable_d = '0;
              state_d  = ST_HELD;
            end else begin
              stable_d = stable_q + SC_W'(1);
            end
          end else begin
            stable_d = '0;
            state_d  = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (none_down_c) begin
            if (32'(stable_q) + 32'd1 >= DEBOUNCE_SCANS) begin
              stable_d = '0;
              state_d  = ST_IDLE;
            end else begin
              stable_d = stable_q + SC_W'(1);
            end
          end else begin
            stable_d = '0;
          end
        end
        default: begin
          stable_d = '0;
          state_d  = ST_IDLE;
        end
      endcase
    end

    if (accept_c) begin
      key_code_d  = acc_code_c;
      key_valid_d = 1'b1;
      if (acc_code_c <= 4'd9) begin
        if (cnt_q < 3'd4) begin
          value_d = (value_q << 3) + (value_q << 1) + 16'(acc_code_c);
          cnt_d   = cnt_q + 3'd1;
        end
      end else if (acc_code_c == 4'd14) begin
        value_d = '0;
        cnt_d   = '0;
      end else if (acc_code_c == 4'd15) begin
        entry_d      = value_q;
        entry_done_d = 1'b1;
        value_d      = '0;
        cnt_d        = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q   <= 4'hF;
      col_sync_q   <= 4'hF;
      dwell_q      <= '0;
      row_q        <= 2'd0;
      row_n_q      <= 4'b1110;
      snap_q       <= 12'hFFF;
      state_q      <= ST_IDLE;
      stable_q     <= '0;
      key_idx_q    <= '0;
      value_q      <= '0;
      cnt_q        <= '0;
      entry_q      <= '0;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      entry_done_q <= 1'b0;
    end else begin
      col_meta_q   <= col_meta_d;
      col_sync_q   <= col_sync_d;
      dwell_q      <= dwell_d;
      row_q        <= row_d;
      row_n_q      <= row_n_d;
      snap_q       <= snap_d;
      state_q      <= state_d;
      stable_q     <= stable_d;
      key_idx_q    <= key_idx_d;
      value_q      <= value_d;
      cnt_q        <= cnt_d;
      entry_q      <= entry_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      entry_done_q <= entry_done_d;
    end
  end

  assign row_n      = row_n_q;
  assign value      = value_q;
  assign digit_cnt  = cnt_q;
  assign entry      = entry_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign entry_done = entry_done_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: keypad model on row_n/col_n, table-driven entry sequence,
// hand-written bounce/multi-key/reset cases, and random presses against a decimal-entry model.
module tb_keypad_entry;

  logic        clk;
  logic        rst;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] value;
  logic [2:0]  digit_cnt;
  logic [15:0] entry;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        entry_done;

  logic [15:0] keys;
  int n_cmp;
  int n_fail;
  int kv_cnt;
  int ed_cnt;

  int m_val;
  int m_cnt;
  int m_entry;
  int m_done;
  int code_of[16];

  typedef struct {
    int idx;
    int code;
    int val;
    int cnt;
    int ent;
    int done;
  } vec_t;
  vec_t tbl[6];

  keypad_entry #(
    .CLK_FREQ(4000),
    .SCAN_HZ(1000),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col_n(col_n),
    .row_n(row_n),
    .value(value),
    .digit_cnt(digit_cnt),
    .entry(entry),
    .key_code(key_code),
    .key_valid(key_valid),
    .entry_done(entry_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad: a closed key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && keys[4*r+c]) col_n[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (entry_done === 1'b1) ed_cnt++;
    n_cmp++;
    if ($countones(~row_n) != 1) begin
      n_fail++;
      $display("FAIL row_onehot: got row_n=%b, required exactly one low bit", row_n);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic model_apply(input int code);
    m_done = 0;
    if (code <= 9) begin
      if (m_cnt < 4) begin
        m_val = m_val * 10 + code;
        m_cnt = m_cnt + 1;
      end
    end else if (code == 14) begin
      m_val = 0;
      m_cnt = 0;
    end else if (code == 15) begin
      m_entry = m_val;
      m_done  = 1;
      m_val   = 0;
      m_cnt   = 0;
    end
  endtask

  // Waits for a key_valid pulse and checks all outputs in the pulse cycle.
  task automatic wait_kv(input int bound, input string name, input int e_code, input int e_val,
                         input int e_cnt, input int e_ent, input int e_done, output int waited);
    bit seen;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < bound) begin
      @(negedge clk);
      waited++;
      if (key_valid === 1'b1) begin
        seen = 1'b1;
        check({name, ".code"}, 32'(key_code), 32'(e_code));
        check({name, ".value"}, 32'(value), 32'(e_val));
        check({name, ".digit_cnt"}, 32'(digit_cnt), 32'(e_cnt));
        check({name, ".entry"}, 32'(entry), 32'(e_ent));
        check({name, ".entry_done"}, 32'(entry_done), 32'(e_done));
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.timeout: got no key_valid in %0d cycles, required one", name, bound);
    end
  endtask

  task automatic press_key(input int idx, input int hold, input int rel, input string name,
                           input int e_code, input int e_val, input int e_cnt, input int e_ent,
                           input int e_done);
    int kv0;
    int waited;
    kv0  = kv_cnt;
    keys = '0;
    keys[idx] = 1'b1;
    wait_kv(hold, name, e_code, e_val, e_cnt, e_ent, e_done, waited);
    repeat (hold - waited) @(negedge clk);
    keys = '0;
    repeat (rel) @(negedge clk);
    check({name, ".pulses"}, 32'(kv_cnt - kv0), 32'd1);
  endtask

  initial begin
    int kv0;
    int ed0;
    int waited;
    logic [3:0] row_exp[17];

    n_cmp   = 0;
    n_fail  = 0;
    kv_cnt  = 0;
    ed_cnt  = 0;
    m_val   = 0;
    m_cnt   = 0;
    m_entry = 0;
    m_done  = 0;
    keys    = '0;
    code_of = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    tbl[0] = '{idx: 0,  code: 1,  val: 1,    cnt: 1, ent: 0,    done: 0};
    tbl[1] = '{idx: 1,  code: 2,  val: 12,   cnt: 2, ent: 0,    done: 0};
    tbl[2] = '{idx: 2,  code: 3,  val: 123,  cnt: 3, ent: 0,    done: 0};
    tbl[3] = '{idx: 4,  code: 4,  val: 1234, cnt: 4, ent: 0,    done: 0};
    tbl[4] = '{idx: 10, code: 9,  val: 1234, cnt: 4, ent: 0,    done: 0};
    tbl[5] = '{idx: 14, code: 15, val: 0,    cnt: 0, ent: 1234, done: 1};

    // Reset state and row rotation
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.row_n", 32'(row_n), 32'(4'b1110));
    check("rst.value", 32'(value), 32'd0);
    check("rst.digit_cnt", 32'(digit_cnt), 32'd0);
    check("rst.entry", 32'(entry), 32'd0);
    check("rst.key_code", 32'(key_code), 32'd0);
    check("rst.key_valid", 32'(key_valid), 32'd0);
    check("rst.entry_done", 32'(entry_done), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k < 4)       row_exp[k] = 4'b1110;
      else if (k < 8)  row_exp[k] = 4'b1101;
      else if (k < 12) row_exp[k] = 4'b1011;
      else if (k < 16) row_exp[k] = 4'b0111;
      else             row_exp[k] = 4'b1110;
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("rotate.k%0d", k), 32'(row_n), 32'(row_exp[k]));
    end

    // Digit entry, overflow digit and commit
    ed0 = ed_cnt;
    for (int i = 0; i < 6; i++) begin
      press_key(tbl[i].idx, 80, 80, $sformatf("tbl%0d", i), tbl[i].code, tbl[i].val,
                tbl[i].cnt, tbl[i].ent, tbl[i].done);
      model_apply(tbl[i].code);
    end
    check("tbl.entry_done_pulses", 32'(ed_cnt - ed0), 32'd1);
    check("tbl.entry_after", 32'(entry), 32'd1234);

    // Bouncy 5, then long hold: one accept, no repeat
    kv0 = kv_cnt;
    keys = '0;
    for (int t = 0; t < 40; t++) begin
      if (t % 3 == 0) keys[5] = ~keys[5];
      @(negedge clk);
    end
    keys = '0;
    keys[5] = 1'b1;
    repeat (280) @(negedge clk);
    check("bounce.pulses", 32'(kv_cnt - kv0), 32'd1);
    model_apply(5);
    check("bounce.code", 32'(key_code), 32'd5);
    check("bounce.value", 32'(value), 32'(m_val));
    keys = '0;
    repeat (80) @(negedge clk);

    // Two keys together never register; releasing one lets the other through
    kv0 = kv_cnt;
    keys = '0;
    keys[8] = 1'b1;
    keys[9] = 1'b1;
    repeat (150) @(negedge clk);
    check("multi.pulses", 32'(kv_cnt - kv0), 32'd0);
    keys[9] = 1'b0;
    model_apply(7);
    wait_kv(100, "multi_release", 7, m_val, m_cnt, m_entry, m_done, waited);
    repeat (60) @(negedge clk);
    keys = '0;
    repeat (80) @(negedge clk);
    check("multi_release.pulses", 32'(kv_cnt - kv0), 32'd1);

    // Reset mid-debounce discards the pending press; the held key re-debounces
    model_apply(9);
    press_key(10, 80, 80, "pre_rst9a", 9, m_val, m_cnt, m_entry, m_done);
    model_apply(9);
    press_key(10, 80, 80, "pre_rst9b", 9, m_val, m_cnt, m_entry, m_done);
    kv0 = kv_cnt;
    keys = '0;
    keys[2] = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_val = 0;
    m_cnt = 0;
    m_entry = 0;
    check("midrst.value", 32'(value), 32'd0);
    check("midrst.digit_cnt", 32'(digit_cnt), 32'd0);
    check("midrst.entry", 32'(entry), 32'd0);
    check("midrst.pulses", 32'(kv_cnt - kv0), 32'd0);
    model_apply(3);
    wait_kv(100, "post_rst", 3, m_val, m_cnt, m_entry, m_done, waited);
    repeat (100) @(negedge clk);
    keys = '0;
    repeat (80) @(negedge clk);
    check("post_rst.pulses", 32'(kv_cnt - kv0), 32'd1);

    // Random clean presses against the entry model
    for (int n = 0; n < 30; n++) begin
      int idx;
      idx = int'($urandom_range(0, 15));
      model_apply(code_of[idx]);
      press_key(idx, int'($urandom_range(70, 100)), int'($urandom_range(70, 100)),
                $sformatf("rand%0d", n), code_of[idx], m_val, m_cnt, m_entry, m_done);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Scans a 4x4 matrix keypad, debounces one key at a time, and builds a decimal number (0…9999) from digit presses. The result is a 16-bit binary value for the game logic. This block is the input-side counterpart of the multiplexed seven-segment display: it drives rows active-low and senses columns the way the display drives digit enables. Its `value` and `entry` outputs feed the score/setting path and can be looped straight into the display for echo.

## Interface
- `CLK_FREQ`, default `` `CLK_FREQ `` (50_000_000): system clock in Hz.
- `SCAN_HZ`, default 1000: row-step rate. Each row dwells SCAN_MAX = CLK_FREQ/SCAN_HZ cycles.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept a press or a release.
- `clk` input 1: system clock. One clock domain only.
- `rst` input 1: synchronous, active-high reset.
- `col_n` input 4: keypad columns, active-low (0 = key closed), asynchronous to `clk`.
- `row_n` output 4: row drive, active-low, exactly one bit low at any time.
- `value` output 16: working number being typed, 0…9999.
- `digit_cnt` output 3: digits currently in `value`, 0…4.
- `entry` output 16: last committed number.
- `key_code` output 4: code of the last accepted key.
- `key_valid` output 1: one-cycle pulse per accepted press.
- `entry_done` output 1: one-cycle pulse when `entry` is updated.

## Operation
- Key map (row, col) → code:
  - row0: 1, 2, 3, A = 1, 2, 3, 10
  - row1: 4, 5, 6, B = 4, 5, 6, 11
  - row2: 7, 8, 9, C = 7, 8, 9, 12
  - row3: \*, 0, #, D = 14, 0, 15, 13
- `col_n` passes through a 2-flop synchronizer before any use.
- Scan:
  - A dwell counter runs 0…SCAN_MAX-1.
  - On the last dwell cycle, the synchronized columns are stored into snapshot bits [4·row+3 : 4·row], and `row_n` rotates row0→1→2→3→0.
  - A full scan completes when the row3 sample is taken.
- Debounce FSM, evaluated once per completed scan:
  - IDLE: if the snapshot has exactly one key down, store its code, set stable_cnt=1, go to ARMING.
  - ARMING:
    - Same single key: stable_cnt++. On reaching DEBOUNCE_SCANS, accept the press (key_valid) and go to HELD.
    - Any other snapshot (none, different key, or ≥2 keys): return to IDLE, stable_cnt=0.
  - HELD: count consecutive all-released scans; any key down resets the count. After DEBOUNCE_SCANS released scans, go to IDLE. No auto-repeat.
  - Multiple keys down never produce an event.
- Accepted-key actions, applied in the same cycle as key_valid:
  - Digit 0–9 with digit_cnt<4: value ← value·10 + d, computed as (v<<3)+(v<<1)+d in 16 bits; digit_cnt++.
  - Digit with digit_cnt=4: value and digit_cnt unchanged; key_valid still pulses.
  - \* (14): value←0, digit_cnt←0.
  - \# (15): entry←value, entry_done pulses, value←0, digit_cnt←0. This applies even when digit_cnt=0, so entry←0.
  - A–D (10–13): key_code and key_valid only; no other state changes.

## Timing
- Reset values:
  - row_n=4'b1110
  - value=0, digit_cnt=0, entry=0, key_code=0
  - key_valid=0, entry_done=0
  - dwell counter=0, FSM=IDLE, stable_cnt=0
- `rst` mid-operation discards any pending press. A key held through reset must pass full debounce again before it is accepted.
- `row_n` changes only on the cycle after a last-dwell sample.
- Press latency:
  - Depends on the scan phase at which the columns close.
  - Worst case from a stable closure to key_valid: 2 (sync) + (DEBOUNCE_SCANS+1)·4·SCAN_MAX + 1 cycles.
- key_valid and entry_done are registered. `value`, `digit_cnt` and `entry` take their new values in the same cycle key_valid is high.
- key_valid and entry_done are high for exactly one cycle per press.

## Test plan
All scenarios use CLK_FREQ=4000, SCAN_HZ=1000 (SCAN_MAX=4, 16-cycle scan) and DEBOUNCE_SCANS=2, with a keypad model that drives col_n from the current row_n.

1. Reset → row_n=1110, then rotates 1101, 1011, 0111 every 4 cycles; all outputs 0.
2. Press 1, 2, 3, 4, each with release → value=1, 12, 123, 1234; digit_cnt=4; exactly one key_valid per press; key_code=1, 2, 3, 4.
3. With value=1234, press 9 → key_valid=1, key_code=9, value stays 1234. Then press # → entry=1234, entry_done one cycle, value=0, digit_cnt=0.
4. Bouncy 5: toggle col_n every 3 cycles for 40 cycles, then hold → exactly one key_valid. Holding 200 cycles more produces no repeat.
5. Hold 7 and 8 together → no key_valid. Release 8 → 7 accepted after debounce.
6. Type 9, 9, assert rst for 1 cycle mid-debounce of a third key → value=0 and no pulse. The key still held after reset is accepted once after full debounce.
